// File: rtl/typedef_collection.sv
// Shared types for the memory path: word size, memory command flags and the
// arbiter's response-pipeline stage record.
package typedef_collection;

    localparam int REGSIZE = 16;

    typedef logic [REGSIZE-1:0] DEFAULT_TYPE;

    typedef enum logic [1:0] {
        MEMORY_STAY  = 2'b00,
        MEMORY_READ  = 2'b01,
        MEMORY_WRITE = 2'b10
    } MEMORY_FLAG_TYPE;

    typedef enum logic {
        OWNER_CPU  = 1'b0,
        OWNER_HOST = 1'b1
    } OWNER_TYPE;

    typedef struct packed {
        logic      valid;
        OWNER_TYPE owner;
    } ARB_STAGE_TYPE;

    function automatic MEMORY_FLAG_TYPE host_flag(input logic write);
        return write ? MEMORY_WRITE : MEMORY_READ;
    endfunction

endpackage

// File: rtl/memory_arbiter_grant.sv
// Combinational grant decision between the CPU and host requesters.
// Build option MEMORY_ARBITER_ROUND_ROBIN_EN: break ties against the last winner.
module memory_arbiter_grant
    import typedef_collection::*;
(
    input  logic      i_cpu_req,
    input  logic      i_host_req,
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    input  OWNER_TYPE i_last_grant,
`endif
    output logic      o_cpu_ready,
    output logic      o_host_ready
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_cpu_ready  = 1'b0;
        o_host_ready = 1'b0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        if (i_cpu_req && i_host_req) begin
            o_cpu_ready  = (i_last_grant == OWNER_HOST);
            o_host_ready = (i_last_grant == OWNER_CPU);
        end else begin
            o_cpu_ready  = i_cpu_req;
            o_host_ready = i_host_req;
        end
`else
        o_cpu_ready  = i_cpu_req;
        o_host_ready = i_host_req && !i_cpu_req;
`endif
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares the memory_unit port between the CPU and the host/loader port.
// Build option MEMORY_ARBITER_ROUND_ROBIN_EN selects round-robin tie-breaking.
module memory_arbiter
    import typedef_collection::*;
#(
    parameter int RESP_LATENCY = 2
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  MEMORY_FLAG_TYPE cpu_rw_flag,
    input  DEFAULT_TYPE     cpu_address,
    input  DEFAULT_TYPE     cpu_write_value,
    output logic            cpu_ready,
    output DEFAULT_TYPE     cpu_read_value,
    output logic            cpu_read_valid,
    input  logic            host_valid,
    input  logic            host_write,
    input  DEFAULT_TYPE     host_address,
    input  DEFAULT_TYPE     host_write_value,
    output logic            host_ready,
    output DEFAULT_TYPE     host_read_value,
    output logic            host_read_valid,
    output MEMORY_FLAG_TYPE mem_rw_flag,
    output DEFAULT_TYPE     mem_address,
    output DEFAULT_TYPE     mem_write_value,
    input  DEFAULT_TYPE     mem_read_value
);

    if (RESP_LATENCY != 2) begin : g_latency_check
        $error("memory_arbiter supports RESP_LATENCY = 2 only");
    end

    logic            w_cpu_req;
    logic            w_host_req;
    logic            w_cpu_grant;
    logic            w_host_grant;
    logic            w_grant_read;
    logic            w_cpu_resp;
    logic            w_host_resp;

    MEMORY_FLAG_TYPE r_mem_rw_flag;
    DEFAULT_TYPE     r_mem_address;
    DEFAULT_TYPE     r_mem_write_value;
    ARB_STAGE_TYPE   r_stage1;
    logic            r_cpu_read_valid;
    logic            r_host_read_valid;
    DEFAULT_TYPE     r_cpu_read_value;
    DEFAULT_TYPE     r_host_read_value;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    OWNER_TYPE       r_last_grant;
`endif

    assign w_cpu_req  = (cpu_rw_flag != MEMORY_STAY);
    assign w_host_req = host_valid;

    memory_arbiter_grant u_grant (
        .i_cpu_req    (w_cpu_req),
        .i_host_req   (w_host_req),
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        .i_last_grant (r_last_grant),
`endif
        .o_cpu_ready  (w_cpu_grant),
        .o_host_ready (w_host_grant)
    );

    // A grant in a reset cycle is discarded, so the requester must not see it.
    assign cpu_ready  = w_cpu_grant && !RESET;
    assign host_ready = w_host_grant && !RESET;

    assign w_grant_read = (w_cpu_grant && (cpu_rw_flag == MEMORY_READ)) ||
                          (w_host_grant && !host_write);
    assign w_cpu_resp   = r_stage1.valid && (r_stage1.owner == OWNER_CPU);
    assign w_host_resp  = r_stage1.valid && (r_stage1.owner == OWNER_HOST);

    // The read_valid/read_value registers act as the second response stage:
    // memory_unit returns data combinationally from the issued address.
    always_ff @(posedge CLOCK) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (RESET) begin
            r_mem_rw_flag     <= MEMORY_STAY;
            r_mem_address     <= '0;
            r_mem_write_value <= '0;
            r_stage1          <= '{valid: 1'b0, owner: OWNER_CPU};
            r_cpu_read_valid  <= 1'b0;
            r_host_read_valid <= 1'b0;
            r_cpu_read_value  <= '0;
            r_host_read_value <= '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            r_last_grant      <= OWNER_HOST;
`endif
        end else begin
            if (w_cpu_grant) begin
                r_mem_rw_flag     <= cpu_rw_flag;
                r_mem_address     <= cpu_address;
                r_mem_write_value <= cpu_write_value;
            end else if (w_host_grant) begin
                r_mem_rw_flag     <= host_flag(host_write);
                r_mem_address     <= host_address;
                r_mem_write_value <= host_write_value;
            end else begin
                r_mem_rw_flag     <= MEMORY_STAY;
            end

            r_stage1.valid <= w_grant_read;
            r_stage1.owner <= w_cpu_grant ? OWNER_CPU : OWNER_HOST;

            r_cpu_read_valid  <= w_cpu_resp;
            r_host_read_valid <= w_host_resp;
            if (w_cpu_resp) begin
                r_cpu_read_value <= mem_read_value;
            end
            if (w_host_resp) begin
                r_host_read_value <= mem_read_value;
            end
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            if (w_cpu_grant) begin
                r_last_grant <= OWNER_CPU;
            end else if (w_host_grant) begin
                r_last_grant <= OWNER_HOST;
            end
`endif
        end
    end

    assign mem_rw_flag     = r_mem_rw_flag;
    assign mem_address     = r_mem_address;
    assign mem_write_value = r_mem_write_value;
    assign cpu_read_valid  = r_cpu_read_valid;
    assign cpu_read_value  = r_cpu_read_value;
    assign host_read_valid = r_host_read_valid;
    assign host_read_value = r_host_read_value;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter with a behavioural memory_unit and
// a transaction-level reference model of grants, memory contents and responses.
`timescale 1ns/1ps
module tb_memory_arbiter;
    import typedef_collection::*;

    logic            CLOCK = 1'b0;
    logic            RESET = 1'b1;
    MEMORY_FLAG_TYPE cpu_rw_flag = MEMORY_STAY;
    DEFAULT_TYPE     cpu_address = '0;
    DEFAULT_TYPE     cpu_write_value = '0;
    logic            cpu_ready;
    DEFAULT_TYPE     cpu_read_value;
    logic            cpu_read_valid;
    logic            host_valid = 1'b0;
    logic            host_write = 1'b0;
    DEFAULT_TYPE     host_address = '0;
    DEFAULT_TYPE     host_write_value = '0;
    logic            host_ready;
    DEFAULT_TYPE     host_read_value;
    logic            host_read_valid;
    MEMORY_FLAG_TYPE mem_rw_flag;
    DEFAULT_TYPE     mem_address;
    DEFAULT_TYPE     mem_write_value;
    DEFAULT_TYPE     mem_read_value;

    memory_arbiter #(.RESP_LATENCY(2)) dut (
        .CLOCK            (CLOCK),
        .RESET            (RESET),
        .cpu_rw_flag      (cpu_rw_flag),
        .cpu_address      (cpu_address),
        .cpu_write_value  (cpu_write_value),
        .cpu_ready        (cpu_ready),
        .cpu_read_value   (cpu_read_value),
        .cpu_read_valid   (cpu_read_valid),
        .host_valid       (host_valid),
        .host_write       (host_write),
        .host_address     (host_address),
        .host_write_value (host_write_value),
        .host_ready       (host_ready),
        .host_read_value  (host_read_value),
        .host_read_valid  (host_read_valid),
        .mem_rw_flag      (mem_rw_flag),
        .mem_address      (mem_address),
        .mem_write_value  (mem_write_value),
        .mem_read_value   (mem_read_value)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        DEFAULT_TYPE data;
        int          due;
    } exp_t;

    exp_t        cpu_q[$];
    exp_t        host_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    DEFAULT_TYPE mem_array [256];
    DEFAULT_TYPE ref_mem [256];
    bit          loaded = 1'b0;
    bit          started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic DEFAULT_TYPE init_val(input int i);
        case (i)
            1:       return 16'h0011;
            2:       return 16'h0022;
            5:       return 16'h003C;
            default: return DEFAULT_TYPE'(16'h5A00 + i);
        endcase
    endfunction

    always @(posedge CLOCK) cyc++;

    // Behavioural memory_unit: combinational read, write on the clock edge.
    assign mem_read_value = mem_array[mem_address[7:0]];
    always @(posedge CLOCK) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem_array[i] <= init_val(i);
            loaded <= 1'b1;
        end else if (mem_rw_flag == MEMORY_WRITE) begin
            mem_array[mem_address[7:0]] <= mem_write_value;
        end
    end

    // Reference model: grants, issued command and memory contents in grant order.
    MEMORY_FLAG_TYPE exp_flag = MEMORY_STAY;
    DEFAULT_TYPE     exp_addr = '0;
    DEFAULT_TYPE     exp_wv = '0;
    bit              rr_prefer_cpu = 1'b1;

    always @(negedge CLOCK) begin
        logic c_req, h_req, e_c, e_h;
        if (!started) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
            started = 1'b1;
        end
        check("mem_rw_flag", 32'(mem_rw_flag), 32'(exp_flag));
        check("mem_address", 32'(mem_address), 32'(exp_addr));
        check("mem_write_value", 32'(mem_write_value), 32'(exp_wv));
        c_req = (cpu_rw_flag != MEMORY_STAY);
        h_req = host_valid;
        e_c = 1'b0;
        e_h = 1'b0;
        if (!RESET) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            if (c_req && h_req) begin
                e_c = rr_prefer_cpu;
                e_h = !rr_prefer_cpu;
            end else begin
                e_c = c_req;
                e_h = h_req;
            end
`else
            e_c = c_req;
            e_h = h_req && !c_req;
`endif
        end
        check("cpu_ready", 32'(cpu_ready), 32'(e_c));
        check("host_ready", 32'(host_ready), 32'(e_h));
        if (RESET) begin
            exp_flag = MEMORY_STAY;
            exp_addr = '0;
            exp_wv = '0;
            rr_prefer_cpu = 1'b1;
        end else if (e_c) begin
            exp_flag = cpu_rw_flag;
            exp_addr = cpu_address;
            exp_wv = cpu_write_value;
            if (cpu_rw_flag == MEMORY_READ) cpu_q.push_back('{ref_mem[cpu_address[7:0]], cyc + 2});
            else ref_mem[cpu_address[7:0]] = cpu_write_value;
            rr_prefer_cpu = 1'b0;
        end else if (e_h) begin
            exp_flag = host_write ? MEMORY_WRITE : MEMORY_READ;
            exp_addr = host_address;
            exp_wv = host_write_value;
            if (!host_write) host_q.push_back('{ref_mem[host_address[7:0]], cyc + 2});
            else ref_mem[host_address[7:0]] = host_write_value;
            rr_prefer_cpu = 1'b1;
        end else begin
            exp_flag = MEMORY_STAY;
        end
    end

    // Response monitor: pops the scoreboard whenever a response is due.
    DEFAULT_TYPE exp_cpu_rv = '0;
    DEFAULT_TYPE exp_host_rv = '0;

    always @(negedge CLOCK) begin
        logic ev_c, ev_h;
        ev_c = (cpu_q.size() > 0) && (cpu_q[0].due == cyc);
        ev_h = (host_q.size() > 0) && (host_q[0].due == cyc);
        check("cpu_read_valid", 32'(cpu_read_valid), 32'(ev_c));
        check("host_read_valid", 32'(host_read_valid), 32'(ev_h));
        if (ev_c) exp_cpu_rv = cpu_q.pop_front().data;
        if (ev_h) exp_host_rv = host_q.pop_front().data;
        check("cpu_read_value", 32'(cpu_read_value), 32'(exp_cpu_rv));
        check("host_read_value", 32'(host_read_value), 32'(exp_host_rv));
        if (RESET) begin
            cpu_q.delete();
            host_q.delete();
            exp_cpu_rv = '0;
            exp_host_rv = '0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic cpu_op(input MEMORY_FLAG_TYPE f, input DEFAULT_TYPE a, input DEFAULT_TYPE d);
        int t = 0;
        cpu_rw_flag = f;
        cpu_address = a;
        cpu_write_value = d;
        do begin
            @(negedge CLOCK);
            t++;
        end while (!cpu_ready && t < 200);
        if (!cpu_ready) begin
            checks++;
            failures++;
            $display("FAIL cpu_handshake_timeout: no cpu_ready after %0d cycles", t);
        end
        @(posedge CLOCK);
        #1;
        cpu_rw_flag = MEMORY_STAY;
    endtask

    task automatic host_op(input logic w, input DEFAULT_TYPE a, input DEFAULT_TYPE d);
        int t = 0;
        host_valid = 1'b1;
        host_write = w;
        host_address = a;
        host_write_value = d;
        do begin
            @(negedge CLOCK);
            t++;
        end while (!host_ready && t < 200);
        if (!host_ready) begin
            checks++;
            failures++;
            $display("FAIL host_handshake_timeout: no host_ready after %0d cycles", t);
        end
        @(posedge CLOCK);
        #1;
        host_valid = 1'b0;
    endtask

    task automatic cpu_driver(input int n);
        for (int k = 0; k < n; k++) begin
            idle($urandom_range(0, 2));
            cpu_op($urandom_range(0, 1) ? MEMORY_WRITE : MEMORY_READ,
                   DEFAULT_TYPE'($urandom_range(0, 31)), DEFAULT_TYPE'($urandom));
        end
    endtask

    task automatic host_driver(input int n);
        for (int k = 0; k < n; k++) begin
            idle($urandom_range(0, 2));
            host_op(1'($urandom_range(0, 1)),
                    DEFAULT_TYPE'($urandom_range(0, 31)), DEFAULT_TYPE'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held three cycles with both requesters active.
        cpu_rw_flag = MEMORY_READ;
        cpu_address = 16'h0007;
        host_valid = 1'b1;
        host_address = 16'h0008;
        repeat (3) @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        cpu_rw_flag = MEMORY_STAY;
        host_valid = 1'b0;
        idle(2);

        cpu_op(MEMORY_READ, 16'h0005, '0);
        idle(3);

        host_op(1'b1, 16'h0010, 16'h00A5);
        host_op(1'b0, 16'h0010, '0);
        idle(3);

        fork
            begin
                for (int k = 0; k < 6; k++) cpu_op(MEMORY_READ, DEFAULT_TYPE'($urandom_range(0, 31)), '0);
            end
            host_op(1'b0, 16'h0003, '0);
        join
        idle(3);

        fork
            cpu_op(MEMORY_READ, 16'h0001, '0);
            host_op(1'b0, 16'h0002, '0);
        join
        idle(3);

        cpu_op(MEMORY_READ, 16'h0005, '0);
        RESET = 1'b1;
        idle(1);
        RESET = 1'b0;
        idle(4);

        fork
            cpu_driver(60);
            host_driver(60);
        join
        idle(5);

        check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
        check("host_queue_drained", 32'(host_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
